// File: rtl/ordered_alloc_issue_ctrl_pkg.sv
// Shared defaults for the ordered allocate/issue controller.
// DP_NUM_WIDTH normally comes from the project-wide constants.vh; the guarded
// definition below only applies when that header has not been read first.
`ifndef DP_NUM_WIDTH
`define DP_NUM_WIDTH 2
`endif

package ordered_alloc_issue_ctrl_pkg;
  localparam int ENT_NUM_DEF  = 8;
  localparam int ENT_SEL_DEF  = 3;
  localparam int DP_WIDTH_DEF = 2;
  localparam int IS_WIDTH_DEF = 2;
endpackage

// File: rtl/ordered_alloc_issue_ctrl_leading_ones_cnt.sv
// Counts the run of ones starting at bit 0 of a W-bit vector.
module leading_ones_cnt #(
  parameter int W = 2
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int CW = $clog2(W + 1);

  logic run;

  // Walk from bit 0 upward; the first zero stops the count
  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & vec[i];
      if (run) cnt = cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ordered_alloc_issue_ctrl.sv
// Circular-buffer allocator with strictly in-order, multi-port issue.
// Handshake: an issue port k transfers when o_issue_sel_vld[k] and
// i_issue_rdy[k] are both high AND every lower port also transfers; the first
// port that does not transfer ends issue for the cycle. Allocation is
// all-or-nothing: i_req_num entries are taken only when o_allocable is high
// and neither flush nor stall is asserted.
module ordered_alloc_issue_ctrl
  import ordered_alloc_issue_ctrl_pkg::*;
#(
  parameter int ENT_NUM  = ENT_NUM_DEF,
  parameter int ENT_SEL  = ENT_SEL_DEF,
  parameter int DP_WIDTH = DP_WIDTH_DEF,
  parameter int IS_WIDTH = IS_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_stall,
  input  logic [`DP_NUM_WIDTH-1:0]     i_req_num,
  output logic                         o_allocable,
  output logic [DP_WIDTH-1:0]          o_alloc_sel_vld,
  output logic [DP_WIDTH*ENT_SEL-1:0]  o_alloc_sel,
  input  logic [ENT_NUM-1:0]           i_vld_vec,
  input  logic [IS_WIDTH-1:0]          i_issue_rdy,
  output logic [IS_WIDTH-1:0]          o_issue_sel_vld,
  output logic [IS_WIDTH*ENT_SEL-1:0]  o_issue_sel,
  output logic [ENT_SEL:0]             o_count,
  output logic                         o_empty,
  output logic                         o_full
);
  localparam logic [ENT_SEL:0] ENT_NUM_W = (ENT_SEL+1)'(ENT_NUM);
  localparam int               LCW       = $clog2(IS_WIDTH + 1);

  logic [ENT_SEL-1:0] alloc_ptr, issue_ptr;
  logic [ENT_SEL:0]   count;
  logic [ENT_SEL-1:0] alloc_ptr_nxt, issue_ptr_nxt;
  logic [ENT_SEL:0]   count_nxt;

  logic [ENT_SEL:0]   free_slots;
  logic [31:0]        req_ext;
  logic [31:0]        free_ext;
  logic               req_legal;
  logic               do_alloc;
  logic [ENT_SEL:0]   alloc_n;
  logic [ENT_SEL:0]   issue_n;
  logic [ENT_SEL:0]   asum, isum, alloc_adv, issue_adv;
  logic               run;
  logic [IS_WIDTH-1:0] issue_acc;
  logic [LCW-1:0]     lead_cnt;

  assign free_slots = ENT_NUM_W - count;
  assign req_ext    = 32'(i_req_num);
  assign free_ext   = 32'(free_slots);
  assign req_legal  = (req_ext <= 32'(DP_WIDTH));

  assign o_allocable = (req_ext <= free_ext);
  assign do_alloc    = !i_flush && !i_stall && o_allocable && req_legal;
  assign alloc_n     = do_alloc ? (ENT_SEL+1)'(i_req_num) : '0;

  // Allocation slot indices and per-port free flags (wrap by truncation)
  always_comb begin
    o_alloc_sel     = '0;
    o_alloc_sel_vld = '0;
    asum            = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      asum = {1'b0, alloc_ptr} + (ENT_SEL+1)'(k);
      o_alloc_sel[k*ENT_SEL +: ENT_SEL] = asum[ENT_SEL-1:0];
      o_alloc_sel_vld[k] = ((ENT_SEL+1)'(k) < free_slots);
    end
  end

  // Issue indices and the contiguous in-order valid prefix
  always_comb begin
    o_issue_sel     = '0;
    o_issue_sel_vld = '0;
    isum            = '0;
    run             = 1'b1;
    for (int k = 0; k < IS_WIDTH; k++) begin
      isum = {1'b0, issue_ptr} + (ENT_SEL+1)'(k);
      o_issue_sel[k*ENT_SEL +: ENT_SEL] = isum[ENT_SEL-1:0];
      run = run & ((ENT_SEL+1)'(k) < count) & i_vld_vec[isum[ENT_SEL-1:0]];
      o_issue_sel_vld[k] = run;
    end
  end

  assign issue_acc = o_issue_sel_vld & i_issue_rdy;

  leading_ones_cnt #(.W(IS_WIDTH)) u_issue_cnt (
    .vec (issue_acc),
    .cnt (lead_cnt)
  );

  assign issue_n = (i_flush || !req_legal) ? '0 : (ENT_SEL+1)'(lead_cnt);

  // Next pointer/occupancy values; flush returns everything to empty
  always_comb begin
    alloc_adv = {1'b0, alloc_ptr} + alloc_n;
    issue_adv = {1'b0, issue_ptr} + issue_n;
    alloc_ptr_nxt = alloc_adv[ENT_SEL-1:0];
    issue_ptr_nxt = issue_adv[ENT_SEL-1:0];
    count_nxt     = count + alloc_n - issue_n;
    if (i_flush) begin
      alloc_ptr_nxt = '0;
      issue_ptr_nxt = '0;
      count_nxt     = '0;
    end
  end

  // State registers; reset wins over everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      issue_ptr <= '0;
      count     <= '0;
    end else begin
      alloc_ptr <= alloc_ptr_nxt;
      issue_ptr <= issue_ptr_nxt;
      count     <= count_nxt;
    end
  end

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == ENT_NUM_W);

  // Request sizes beyond the port count are an upstream bug
  req_legal_a: assert property (@(posedge clk) disable iff (!rst_n) req_legal);
endmodule
